// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single byte-wide-write memory.
// Round-robin on ties, request checking at grant, multi-cycle byte-serial stores.
module mem_arbiter #(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned LP_AW = 32;
    localparam int unsigned LP_DW = 32;

    localparam logic [1:0] LP_SZ_BYTE = 2'b00;
    localparam logic [1:0] LP_SZ_HALF = 2'b01;
    localparam logic [1:0] LP_SZ_WORD = 2'b10;

    // One extra bit so addr+bytes-1 cannot wrap.
    localparam logic [LP_AW:0] LP_MEM_LIMIT = 33'(MEM_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Request context held from grant until the ack.
    typedef struct packed {
        logic             gnt_d;
        logic [1:0]       size;
        logic [LP_AW-1:0] addr;
        logic [LP_DW-1:0] wdata;
    } req_t;

    // Index of the last byte of an access of the given size.
    function automatic logic [1:0] f_last_idx(input logic [1:0] size);
        logic [1:0] idx;
        case (size)
            LP_SZ_BYTE: idx = 2'd0;
            LP_SZ_HALF: idx = 2'd1;
            default:    idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Misalignment, illegal size or running past the end of memory.
    function automatic logic f_req_err(input logic [LP_AW-1:0] addr, input logic [1:0] size);
        logic            misal;
        logic            bad_size;
        logic [LP_AW:0]  end_addr;
        misal    = 1'b0;
        bad_size = 1'b0;
        end_addr = {1'b0, addr};
        case (size)
            LP_SZ_BYTE: begin
                misal    = 1'b0;
                end_addr = {1'b0, addr};
            end
            LP_SZ_HALF: begin
                misal    = addr[0];
                end_addr = {1'b0, addr} + 33'd1;
            end
            LP_SZ_WORD: begin
                misal    = |addr[1:0];
                end_addr = {1'b0, addr} + 33'd3;
            end
            default: bad_size = 1'b1;
        endcase
        return bad_size | misal | (end_addr >= LP_MEM_LIMIT);
    endfunction

    // Big-endian byte idx of a store value of the given size.
    function automatic logic [7:0] f_wbyte(input logic [LP_DW-1:0] wdata, input logic [1:0] size,
                                           input logic [1:0] idx);
        logic [1:0] sh;
        sh = f_last_idx(size) - idx;
        return wdata[{sh, 3'b000} +: 8];
    endfunction

    // Load data is the leading bytes of the memory word, zero extended.
    function automatic logic [LP_DW-1:0] f_load(input logic [LP_DW-1:0] rdata, input logic [1:0] size);
        logic [LP_DW-1:0] val;
        case (size)
            LP_SZ_WORD: val = rdata;
            LP_SZ_HALF: val = {16'b0, rdata[31:16]};
            default:    val = {24'b0, rdata[31:24]};
        endcase
        return val;
    endfunction

    state_t           r_state;
    req_t             r_req;
    logic [1:0]       r_cnt;
    logic             r_last_d;

    state_t           w_state_n;
    req_t             w_req_n;
    logic [1:0]       w_cnt_n;
    logic [1:0]       w_cnt_inc;
    logic             w_last_d_n;
    logic             w_any;
    logic             w_pick_d;
    req_t             w_new;
    logic             w_new_we;
    logic             w_new_err;
    logic             w_if_ack_n;
    logic             w_if_err_n;
    logic [LP_DW-1:0] w_if_rdata_n;
    logic             w_d_ack_n;
    logic             w_d_err_n;
    logic [LP_DW-1:0] w_d_rdata_n;
    logic             w_m_read_n;
    logic             w_m_write_n;
    logic [LP_AW-1:0] w_m_addr_n;
    logic [LP_DW-1:0] w_m_wdata_n;
    logic             w_busy_n;
    logic             w_resp;
    logic             w_resp_d;
    logic             w_resp_err;
    logic [LP_DW-1:0] w_resp_data;

    // Grant selection and the candidate request context built from the ports.
    always_comb begin
        w_any       = if_req | d_req;
        w_pick_d    = d_req & (~if_req | ~r_last_d);
        w_new       = '0;
        w_new.gnt_d = w_pick_d;
        w_new.size  = w_pick_d ? d_size  : LP_SZ_WORD;
        w_new.addr  = w_pick_d ? d_addr  : if_addr;
        w_new.wdata = w_pick_d ? d_wdata : '0;
        w_new_we    = w_pick_d & d_we;
        w_new_err   = f_req_err(w_new.addr, w_new.size);
        w_cnt_inc   = r_cnt + 2'd1;
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_n    = r_state;
        w_req_n      = r_req;
        w_cnt_n      = r_cnt;
        w_last_d_n   = r_last_d;
        w_if_ack_n   = 1'b0;
        w_if_err_n   = 1'b0;
        w_if_rdata_n = if_rdata;
        w_d_ack_n    = 1'b0;
        w_d_err_n    = 1'b0;
        w_d_rdata_n  = d_rdata;
        w_m_read_n   = 1'b0;
        w_m_write_n  = 1'b0;
        w_m_addr_n   = '0;
        w_m_wdata_n  = '0;
        w_resp       = 1'b0;
        w_resp_d     = r_req.gnt_d;
        w_resp_err   = 1'b0;
        w_resp_data  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_req_n    = w_new;
                    w_last_d_n = w_new.gnt_d;
                    w_cnt_n    = 2'd0;
                    w_resp_d   = w_new.gnt_d;
                    if (w_new_err) begin
                        w_state_n  = ST_RESP;
                        w_resp     = 1'b1;
                        w_resp_err = 1'b1;
                    end else if (w_new_we) begin
                        w_state_n   = ST_WR;
                        w_m_write_n = 1'b1;
                        w_m_addr_n  = w_new.addr;
                        w_m_wdata_n = {24'b0, f_wbyte(w_new.wdata, w_new.size, 2'd0)};
                    end else begin
                        w_state_n  = ST_RD;
                        w_m_read_n = 1'b1;
                        w_m_addr_n = w_new.addr;
                    end
                end
            end
            ST_RD: begin
                w_state_n   = ST_RESP;
                w_resp      = 1'b1;
                w_resp_data = f_load(m_rdata, r_req.size);
            end
            ST_WR: begin
                if (r_cnt == f_last_idx(r_req.size)) begin
                    w_state_n = ST_RESP;
                    w_resp    = 1'b1;
                end else begin
                    w_cnt_n     = w_cnt_inc;
                    w_m_write_n = 1'b1;
                    w_m_addr_n  = r_req.addr + 32'(w_cnt_inc);
                    w_m_wdata_n = {24'b0, f_wbyte(r_req.wdata, r_req.size, w_cnt_inc)};
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (w_resp) begin
            if (w_resp_d) begin
                w_d_ack_n   = 1'b1;
                w_d_err_n   = w_resp_err;
                w_d_rdata_n = w_resp_data;
            end else begin
                w_if_ack_n   = 1'b1;
                w_if_err_n   = w_resp_err;
                w_if_rdata_n = w_resp_data;
            end
        end

        w_busy_n = (w_state_n != ST_IDLE);
    end

    // State, request context and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_req    <= '0;
            r_cnt    <= 2'd0;
            r_last_d <= 1'b1;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= '0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
            m_read   <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_req    <= w_req_n;
            r_cnt    <= w_cnt_n;
            r_last_d <= w_last_d_n;
            if_ack   <= w_if_ack_n;
            if_err   <= w_if_err_n;
            if_rdata <= w_if_rdata_n;
            d_ack    <= w_d_ack_n;
            d_err    <= w_d_err_n;
            d_rdata  <= w_d_rdata_n;
            m_read   <= w_m_read_n;
            m_write  <= w_m_write_n;
            m_addr   <= w_m_addr_n;
            m_wdata  <= w_m_wdata_n;
            busy     <= w_busy_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 512-byte big-endian memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        busy;

    mem_arbiter #(.MEM_BYTES(512)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:511];
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    int          strb_cnt = 0;
    int          both_cnt = 0;
    int          ack_cnt  = 0;
    int          n_pass   = 0;
    int          n_total  = 0;

    // Memory read port: four bytes from m_addr, zero beyond the end.
    always_comb begin : mem_rd
        logic [31:0] a;
        m_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            a = m_addr + 32'(k);
            if (a < 32'd512) m_rdata[31-8*k -: 8] = mem[a[8:0]];
        end
    end

    // Memory write port and bus activity monitor.
    always @(posedge clk) begin
        if (m_write) begin
            if (m_addr < 32'd512) mem[m_addr[8:0]] = m_wdata[7:0];
            wlog_a.push_back(m_addr);
            wlog_d.push_back(m_wdata);
        end
        if (m_read || m_write) strb_cnt++;
        if (m_read && m_write) both_cnt++;
        if (if_ack) ack_cnt++;
        if (d_ack)  ack_cnt++;
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [1:0]  d_size;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_strb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                                input logic [1:0] sz, input logic [31:0] da, input logic [31:0] wd,
                                input logic ee, input logic [31:0] er, input int el, input int es);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = we; v.d_size = sz;
        v.d_addr = da; v.d_wdata = wd; v.exp_err = ee; v.exp_rdata = er;
        v.exp_lat = el; v.exp_strb = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 8) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " flags"}, {25'b0, if_ack, if_err, d_ack, d_err, m_read, m_write, busy}, 32'h0);
        chk({tag, " if_rdata"}, if_rdata, 32'h0);
        chk({tag, " d_rdata"}, d_rdata, 32'h0);
        chk({tag, " m_addr"}, m_addr, 32'h0);
        chk({tag, " m_wdata"}, m_wdata, 32'h0);
    endtask

    // Single-requester transaction; inputs are scrambled right after the grant edge.
    task automatic run_txn(input vec_t v, input string nm);
        int   lat;
        int   s0;
        logic got;
        wait_idle();
        s0 = strb_cnt;
        if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_size = v.d_size; d_addr = v.d_addr; d_wdata = v.d_wdata;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if_ack || d_ack) got = 1'b1;
            if (lat == 1) begin
                if_req = 1'b0; d_req = 1'b0; d_we = ~d_we; d_size = 2'b11;
                if_addr = 32'h20; d_addr = 32'h10; d_wdata = 32'hFFFF_FFFF;
            end
        end
        if (!got) begin
            chk({nm, " ack timeout"}, 32'(lat), 32'(v.exp_lat));
        end else begin
            chk({nm, " if_ack"}, {31'b0, if_ack}, {31'b0, ~v.d_req});
            chk({nm, " d_ack"}, {31'b0, d_ack}, {31'b0, v.d_req});
            chk({nm, " err"}, {31'b0, v.d_req ? d_err : if_err}, {31'b0, v.exp_err});
            if (!(v.d_req && v.d_we))
                chk({nm, " rdata"}, v.d_req ? d_rdata : if_rdata, v.exp_rdata);
            chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
            chk({nm, " strobes"}, 32'(strb_cnt - s0), 32'(v.exp_strb));
        end
    endtask

    // Both ports request together; the winner acks in cycle 2, the loser in cycle 5.
    task automatic run_tie(input logic [31:0] ia, input logic [31:0] da, input logic first_d,
                           input logic [31:0] ei, input logic [31:0] ed);
        int cyc, ic, dc, ov;
        wait_idle();
        if_req = 1'b1; if_addr = ia;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = da;
        cyc = 0; ic = 0; dc = 0; ov = 0;
        while ((ic == 0 || dc == 0) && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) chk("tie busy c1", {31'b0, busy}, 32'd1);
            if (cyc == 3) chk("tie idle c3", {31'b0, busy}, 32'd0);
            if (if_ack && d_ack) ov++;
            if (if_ack) begin
                ic = cyc; if_req = 1'b0;
                chk("tie if_rdata", if_rdata, ei);
                chk("tie if_err", {31'b0, if_err}, 32'd0);
            end
            if (d_ack) begin
                dc = cyc; d_req = 1'b0;
                chk("tie d_rdata", d_rdata, ed);
            end
        end
        chk("tie if_ack cycle", 32'(ic), first_d ? 32'd5 : 32'd2);
        chk("tie d_ack cycle", 32'(dc), first_d ? 32'd2 : 32'd5);
        chk("tie ack overlap", 32'(ov), 32'd0);
    endtask

    initial begin
        int a0, k0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
        mem[32] = 8'h55; mem[33] = 8'h66; mem[34] = 8'h77; mem[35] = 8'h88;

        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
        d_addr = '0; d_wdata = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");

        // Tie straight after reset: fetch first.
        run_tie(32'h10, 32'h20, 1'b0, 32'h1122_3344, 32'h5566_7788);

        // Word store, byte-serial big-endian.
        wlog_a.delete(); wlog_d.delete();
        run_txn(mk(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h40, 32'hA1B2_C3D4, 1'b0, 32'h0, 5, 4), "st word");
        chk("st word nwrites", 32'(wlog_a.size()), 32'd4);
        if (wlog_a.size() == 4) begin
            chk("st word a0", wlog_a[0], 32'h40); chk("st word d0", wlog_d[0], 32'hA1);
            chk("st word a1", wlog_a[1], 32'h41); chk("st word d1", wlog_d[1], 32'hB2);
            chk("st word a2", wlog_a[2], 32'h42); chk("st word d2", wlog_d[2], 32'hC3);
            chk("st word a3", wlog_a[3], 32'h43); chk("st word d3", wlog_d[3], 32'hD4);
        end

        vecs.push_back(mk(0, 0,      1, 0, 2'b10, 32'h40,  0,            0, 32'hA1B2_C3D4, 2, 1));
        vecs.push_back(mk(1, 32'h40, 0, 0, 2'b00, 0,       0,            0, 32'hA1B2_C3D4, 2, 1));
        vecs.push_back(mk(0, 0,      1, 1, 2'b01, 32'h42,  32'h0000_1234, 0, 32'h0,        3, 2));
        vecs.push_back(mk(0, 0,      1, 0, 2'b01, 32'h42,  0,            0, 32'h0000_1234, 2, 1));
        vecs.push_back(mk(0, 0,      1, 0, 2'b00, 32'h43,  0,            0, 32'h0000_0034, 2, 1));
        vecs.push_back(mk(0, 0,      1, 0, 2'b00, 32'h40,  0,            0, 32'h0000_00A1, 2, 1));
        vecs.push_back(mk(0, 0,      1, 0, 2'b01, 32'h40,  0,            0, 32'h0000_A1B2, 2, 1));
        vecs.push_back(mk(0, 0,      1, 0, 2'b10, 32'h40,  0,            0, 32'hA1B2_1234, 2, 1));
        vecs.push_back(mk(0, 0,      1, 1, 2'b00, 32'h1FF, 32'hFFFF_FF5A, 0, 32'h0,        2, 1));
        vecs.push_back(mk(0, 0,      1, 0, 2'b00, 32'h1FF, 0,            0, 32'h0000_005A, 2, 1));
        vecs.push_back(mk(0, 0,      1, 0, 2'b10, 32'h41,  0,            1, 32'h0,         1, 0));
        vecs.push_back(mk(1, 32'h06, 0, 0, 2'b00, 0,       0,            1, 32'h0,         1, 0));
        vecs.push_back(mk(0, 0,      1, 0, 2'b10, 32'h1FE, 0,            1, 32'h0,         1, 0));
        vecs.push_back(mk(0, 0,      1, 0, 2'b10, 32'h200, 0,            1, 32'h0,         1, 0));
        vecs.push_back(mk(1, 32'h200, 0, 0, 2'b00, 0,      0,            1, 32'h0,         1, 0));
        vecs.push_back(mk(0, 0,      1, 1, 2'b01, 32'h1FF, 32'h1111,     1, 32'h0,         1, 0));
        vecs.push_back(mk(0, 0,      1, 0, 2'b11, 32'h40,  0,            1, 32'h0,         1, 0));
        vecs.push_back(mk(0, 0,      1, 1, 2'b01, 32'h1FE, 32'h0000_BEEF, 0, 32'h0,        3, 2));
        vecs.push_back(mk(0, 0,      1, 0, 2'b10, 32'h1FC, 0,            0, 32'h0000_BEEF, 2, 1));
        vecs.push_back(mk(0, 0,      1, 1, 2'b10, 32'h200, 32'h1234_5678, 1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0,      1, 0, 2'b00, 32'h200, 0,            1, 32'h0,         1, 0));
        vecs.push_back(mk(1, 32'h1FC, 0, 0, 2'b00, 0,      0,            0, 32'h0000_BEEF, 2, 1));
        vecs.push_back(mk(0, 0,      1, 0, 2'b10, 32'h40,  0,            0, 32'hA1B2_1234, 2, 1));

        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Fetch data held across a data-port transaction.
        chk("if_rdata hold", if_rdata, 32'h0000_BEEF);

        // After a fetch grant, a tie goes to the data port.
        run_txn(mk(1, 32'h10, 0, 0, 2'b00, 0, 0, 0, 32'h1122_3344, 2, 1), "fetch pre-tie");
        run_tie(32'h40, 32'h20, 1'b1, 32'hA1B2_1234, 32'h5566_7788);

        // Reset during the second write cycle of a word store.
        wait_idle();
        k0 = wlog_a.size();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h80; d_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        d_req = 1'b0;
        a0 = ack_cnt;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("mid-write reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort writes", 32'(wlog_a.size() - k0), 32'd1);
        chk("abort mem", {mem[128], mem[129], mem[130], mem[131]}, 32'hCA00_0000);
        chk("abort no ack", 32'(ack_cnt - a0), 32'd0);
        check_all_zero("after abort");

        run_txn(mk(0, 0, 1, 0, 2'b10, 32'h80, 0, 0, 32'hCA00_0000, 2, 1), "ld after abort");
        run_tie(32'h10, 32'h20, 1'b0, 32'h1122_3344, 32'h5566_7788);

        chk("read+write overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 512, meaning the byte capacity of the shared memory; legal addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have if_req / if_addr, input, 1 / 32, the instruction-fetch word read request and its byte address.
REQ-005 SHALL have if_ack / if_err / if_rdata, output, 1 / 1 / 32, the fetch completion pulse, error flag and fetched word.
REQ-006 SHALL have d_req / d_we / d_size / d_addr / d_wdata, input, 1 / 1 / 2 / 32 / 32, the data-port request, write enable, size (00 byte, 01 half, 10 word, 11 illegal), byte address and store data.
REQ-007 SHALL have d_ack / d_err / d_rdata, output, 1 / 1 / 32, the data completion pulse, error flag and load data.
REQ-008 SHALL have m_read / m_write / m_addr / m_wdata, output, 1 / 1 / 32 / 32, the memory read strobe, single-byte write strobe, byte address and write data (only bits [7:0] are written).
REQ-009 SHALL have m_rdata, input, 32, the combinational memory read word, {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
REQ-010 SHALL have busy, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL implement the states IDLE, RD, WR and RESP.
REQ-012 In IDLE with exactly one requester active, it SHALL grant that requester, latch its address, size, write enable and data, and leave IDLE on the next edge.
REQ-013 In IDLE with both requesters active, it SHALL grant the requester not granted most recently (round-robin) and update the last-grant flag on the grant.
REQ-014 A latched request SHALL be checked for errors at grant: fetch address with bits [1:0] nonzero; data size 11; data address not aligned to its size; address+bytes-1 >= MEM_BYTES.
REQ-015 An erroneous request SHALL go directly to RESP, assert no memory strobe, and pulse ack with err=1 and rdata=0.
REQ-016 A valid read SHALL spend exactly one cycle in RD with m_read=1 and m_addr=the latched address, capture m_rdata at the end of that cycle, then enter RESP.
REQ-017 Load data SHALL be returned as follows: word gives m_rdata; half gives {16'b0, m_rdata[31:16]}; byte gives {24'b0, m_rdata[31:24]}; sign extension is not done here.
REQ-018 A valid write SHALL stay in WR for N = 1, 2 or 4 cycles (byte, half, word), driving a 2-bit byte counter i from 0.
REQ-019 In each WR cycle it SHALL drive m_write=1 and m_addr=addr+i, where m_wdata[7:0] is the big-endian byte i of the store value.
REQ-020 Byte order for REQ-019: word takes bytes [31:24], [23:16], [15:8], [7:0] in order; half takes [15:8] then [7:0]; a byte store takes [7:0].
REQ-021 After the last WR cycle the block SHALL enter RESP.
REQ-022 RESP SHALL last one cycle, pulsing the granted requester's ack (with err and rdata valid), then return to IDLE.
REQ-023 if_rdata / d_rdata SHALL hold their values until that port's next ack.
REQ-024 Requests SHALL NOT be sampled outside IDLE, so input changes after grant are ignored.
REQ-025 A requester that drops req before ack SHALL still receive its ack pulse.
REQ-026 The block SHALL NOT issue a back-to-back grant in RESP; IDLE is always visited for at least one cycle.
REQ-027 Latency from grant edge to ack: valid read gives ack in the 2nd cycle; write gives ack in cycle N+1; error gives ack in the 1st cycle.
REQ-028 m_read and m_write SHALL never be high together and SHALL be 0 outside RD and WR.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force state to IDLE, the byte counter to 0, and last-grant to the data port, so that fetch wins the first tie.
REQ-030 Reset SHALL drive all outputs to 0, including the registered rdata values.
REQ-031 Reset asserted mid-WR SHALL abort with no further byte writes and no ack; earlier bytes stay written.

Verification
REQ-032 Both ports request together straight after reset, with if_addr=0x10 and d_addr=0x20 (word read): fetch is acked first and data second, with no cycle overlap.
REQ-033 Word store of d_wdata=0xA1B2C3D4 at address 0x40: four m_write cycles at 0x40..0x43 with bytes A1, B2, C3, D4; d_ack follows in cycle 5; a word read at 0x40 then returns 0xA1B2C3D4.
REQ-034 Half store of 0x00001234 at 0x42 followed by a half load: d_rdata=0x00001234; a byte load at 0x43 returns 0x00000034.
REQ-035 Misaligned accesses, d_addr=0x41 with word size and if_addr=0x06: ack in the 1st cycle with err=1 and no m_read or m_write activity.
REQ-036 Word access at address 0x1FE (MEM_BYTES=512): d_err=1. Then rst pulsed low in the 2nd WR cycle of a word store: only byte 0 is written, no ack, and outputs are 0.
